freq_generator: RTL and testbench

- Programmable square-wave source, the stimulus-side counterpart of the frequency counter.
- Drives OUT at a frequency chosen by a 4-bit select code, in continuous or burst mode.
- Used on-board as a self-test source feeding the counter's IN, and as a general test-signal generator.
- Fully synchronous to CLK. Frequency changes take effect only at full-period boundaries, so OUT never produces runt pulses.

---
 rtl/freq_generator.sv | 127 ++++++++++++
 tb/tb_freq_generator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/freq_generator.sv
// Programmable square-wave source: half-period = BASE_HALF << min(sel, MAX_SEL) cycles,
// continuous or burst mode, with frequency changes applied only at full-period boundaries.
module freq_generator #(
  parameter int BASE_HALF = 50,
  parameter int MAX_SEL   = 10,
  parameter int CNT_W     = 32,
  parameter int BURST_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [3:0]         sel,
  input  logic [BURST_W-1:0] burst,
  output logic               out,
  output logic               active,
  output logic               done,
  output logic [BURST_W-1:0] periods
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, HOLD} state_t;

  localparam logic [3:0]       MAX_SEL_C = 4'(MAX_SEL);
  localparam logic [CNT_W-1:0] BASE_C    = CNT_W'(BASE_HALF);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [3:0]         sel_reg, sel_next;
  logic [BURST_W-1:0] burst_reg, burst_next;
  logic [BURST_W-1:0] periods_reg, periods_next;
  logic               out_reg, out_next;
  logic               active_reg, active_next;
  logic               done_reg, done_next;

  logic [3:0]         sel_clamp;
  logic [CNT_W-1:0]   reload_new;
  logic [CNT_W-1:0]   reload_cur;
  logic [BURST_W-1:0] periods_inc;

  assign sel_clamp   = (sel > MAX_SEL_C) ? MAX_SEL_C : sel;
  // reload_new uses the live select code (period start); reload_cur the latched one (mid-period)
  assign reload_new  = (BASE_C << sel_clamp) - ONE_C;
  assign reload_cur  = (BASE_C << sel_reg) - ONE_C;
  assign periods_inc = periods_reg + BURST_W'(1);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    sel_next     = sel_reg;
    burst_next   = burst_reg;
    periods_next = periods_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en) begin
          sel_next     = sel_clamp;
          burst_next   = burst;
          periods_next = '0;
          cnt_next     = reload_new;
          state_next   = HIGH;
        end
      end
      HIGH: begin
        if (cnt_reg == '0) begin
          cnt_next   = reload_cur;
          state_next = LOW;
        end else begin
          cnt_next = cnt_reg - ONE_C;
        end
      end
      LOW: begin
        if (cnt_reg == '0) begin
          periods_next = periods_inc;
          if ((burst_reg != '0) && (periods_inc == burst_reg)) begin
            done_next  = 1'b1;
            state_next = HOLD;
          end else if (!en) begin
            state_next = IDLE;
          end else begin
            sel_next   = sel_clamp;
            cnt_next   = reload_new;
            state_next = HIGH;
          end
        end else begin
          cnt_next = cnt_reg - ONE_C;
        end
      end
      HOLD: begin
        // a new burst needs en to drop first
        if (!en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    out_next    = (state_next == HIGH);
    active_next = (state_next == HIGH) || (state_next == LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sel_reg     <= '0;
      burst_reg   <= '0;
      periods_reg <= '0;
      out_reg     <= 1'b0;
      active_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sel_reg     <= sel_next;
      burst_reg   <= burst_next;
      periods_reg <= periods_next;
      out_reg     <= out_next;
      active_reg  <= active_next;
      done_reg    <= done_next;
    end
  end

  assign out     = out_reg;
  assign active  = active_reg;
  assign done    = done_reg;
  assign periods = periods_reg;

endmodule

// File: tb/tb_freq_generator.sv
// Directed bench for freq_generator: phase lengths, burst completion, mid-run changes,
// async reset and select clamping, all with hand-computed expectations.
module tb_freq_generator;

  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [3:0]    sel = 4'd0;
  logic [BW-1:0] burst = '0;
  logic          out, active, done;
  logic [BW-1:0] periods;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  freq_generator #(
    .BASE_HALF(50),
    .MAX_SEL  (3),
    .CNT_W    (16),
    .BURST_W  (BW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .sel    (sel),
    .burst  (burst),
    .out    (out),
    .active (active),
    .done   (done),
    .periods(periods)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("check %s: got=%0d ok", tag, got);
    end
  endtask

  // counts negedges while out holds lvl and the generator is active; bounded
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (out === lvl && active === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int lo_n;

    repeat (2) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_periods", periods, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // continuous, sel 0: 50/50
    sel = 4'd0; burst = '0; en = 1'b1;
    @(negedge clk);
    chk("t1_rise", out, 1);
    chk("t1_active", active, 1);
    for (int k = 1; k <= 3; k++) begin
      run_len(1'b1, n); chk("t1_high", n, 50);
      run_len(1'b0, n); chk("t1_low", n, 50);
      chk("t1_periods", periods, k);
    end
    chk("t1_no_done", done_cnt, 0);

    // en dropped at cycle 10 of HIGH: period completes, then idle
    repeat (9) @(negedge clk);
    en = 1'b0;
    run_len(1'b1, n); chk("t4_high_rest", n, 41);
    run_len(1'b0, n); chk("t4_low", n, 50);
    chk("t4_out", out, 0);
    chk("t4_active", active, 0);
    chk("t4_periods", periods, 4);
    repeat (3) @(negedge clk);
    chk("t4_idle_active", active, 0);
    chk("t4_no_done", done_cnt, 0);

    // sel change at cycle 20 of HIGH takes effect next period
    en = 1'b1;
    @(negedge clk);
    chk("t3_rise", out, 1);
    chk("t3_periods_clr", periods, 0);
    repeat (19) @(negedge clk);
    sel = 4'd2;
    run_len(1'b1, n); chk("t3_high_rest", n, 31);
    run_len(1'b0, n); chk("t3_low_old", n, 50);
    chk("t3_periods1", periods, 1);
    run_len(1'b1, n); chk("t3_high_new", n, 200);
    run_len(1'b0, n); chk("t3_low_new", n, 200);
    chk("t3_periods2", periods, 2);

    // async reset mid-HIGH
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_async", out, 0);
    chk("t5_active", active, 0);
    chk("t5_periods", periods, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_restart", out, 1);
    chk("t5_periods_after", periods, 0);
    run_len(1'b1, n); chk("t5_high", n, 200);
    en = 1'b0;
    run_len(1'b0, n); chk("t5_low", n, 200);
    chk("t5_idle", active, 0);
    chk("t5_periods_end", periods, 1);

    // burst of 3 at sel 3; burst input change mid-run has no effect
    sel = 4'd3; burst = 4'd3; en = 1'b1;
    @(negedge clk);
    chk("t2_rise", out, 1);
    burst = '0;
    for (int k = 1; k <= 3; k++) begin
      run_len(1'b1, n); chk("t2_high", n, 400);
      run_len(1'b0, n); chk("t2_low", n, 400);
      if (k < 3) chk("t2_periods", periods, k);
    end
    chk("t2_done", done, 1);
    chk("t2_periods_final", periods, 3);
    chk("t2_active_hold", active, 0);
    chk("t2_out_hold", out, 0);
    @(negedge clk);
    chk("t2_done_pulse", done, 0);
    repeat (20) @(negedge clk);
    chk("t2_hold_out", out, 0);
    chk("t2_hold_active", active, 0);
    chk("t2_hold_periods", periods, 3);
    chk("t2_done_count", done_cnt, 1);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("t2_rearm", out, 1);
    chk("t2_rearm_periods", periods, 0);
    en = 1'b0;
    run_len(1'b1, n);
    run_len(1'b0, n);
    chk("t2_idle_again", active, 0);

    // sel 15 clamps to 3; 4-bit periods wraps 15 -> 0
    sel = 4'd15; burst = '0; en = 1'b1;
    @(negedge clk);
    chk("t6_rise", out, 1);
    for (int k = 1; k <= 16; k++) begin
      run_len(1'b1, n);
      run_len(1'b0, lo_n);
      if (k == 1) begin
        chk("t6_high_clamp", n, 400);
        chk("t6_low_clamp", lo_n, 400);
      end
      if (k == 15) chk("t6_periods15", periods, 15);
      if (k == 16) chk("t6_periods_wrap", periods, 0);
    end
    chk("t6_no_done", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
